cam_pattern_gen: RTL and testbench
==================================

CAM_PATTERN_GEN -- requirements
Module: cam_pattern_gen

Interface
REQ-001 SHALL have parameter TAM_LINE, default 160, active pixels per row (2 bytes each, RGB565).
REQ-002 SHALL have parameter TAM_ROW, default 120, active rows per frame.
REQ-003 SHALL have parameter BLACK_TAM_LINE, default 4, blanking bytes per row after the active bytes.
REQ-004 SHALL have parameter BLACK_TAM_ROW, default 4, blanking rows at the start of the frame.
REQ-005 SHALL have parameter VSYNC_ROWS, default 2, count of leading rows with CAM_vsync high (1 ≤ VSYNC_ROWS ≤ BLACK_TAM_ROW).
REQ-006 SHALL have parameter TRI_SLOPE, default 2, triangle slope in pixels per row.
REQ-007 SHALL have ports, in this order:
- clk  in  1  system clock.
- CAM_reset  in  1  asynchronous, active-low reset.
- en  in  1  run enable, sampled only at frame boundaries.
- mode  in  3  pattern select, latched at frame start.
- CAM_pclk  out  1  emulated pixel clock, clk/2.
- CAM_vsync  out  1  frame sync.
- CAM_href  out  1  line valid.
- CAM_px_data  out  8  pixel byte.
- frame_start  out  1  one-clk pulse at each frame start.
- frame_cnt  out  16  completed-frame count.

Function
REQ-008 SHALL toggle an internal phase bit every clk and drive CAM_pclk from it. The first toggle after reset SHALL bring CAM_pclk high.
REQ-009 SHALL update every other output and counter only on the clk edge where CAM_pclk goes 1->0, so outputs are stable across each CAM_pclk rising edge.
REQ-010 SHALL keep byte counter line_cnt in the range 0..2*TAM_LINE+BLACK_TAM_LINE-1 and row counter row_cnt in 0..TAM_ROW+BLACK_TAM_ROW-1. Widths SHALL be $clog2-derived. line_cnt wraps and increments row_cnt; row_cnt wraps to 0.
REQ-011 SHALL implement states IDLE and FRAME. IDLE->FRAME when en=1 at a falling-pclk update. FRAME->FRAME at row_cnt wrap if en=1. FRAME->IDLE at row_cnt wrap if en=0.
REQ-012 In IDLE, SHALL drive CAM_vsync=1, CAM_href=0, CAM_px_data=0, with counters held at 0.
REQ-013 In FRAME, SHALL drive CAM_vsync=1 iff row_cnt<VSYNC_ROWS.
REQ-014 In FRAME, SHALL drive CAM_href=1 iff row_cnt≥BLACK_TAM_ROW and line_cnt<2*TAM_LINE.
REQ-015 SHALL drive CAM_px_data=0 whenever CAM_href=0.
REQ-016 SHALL pulse frame_start for one clk on entry to row 0 of each frame, and latch mode at that instant. Mid-frame mode changes SHALL be ignored.
REQ-017 SHALL increment frame_cnt by 1 (mod 2^16) at each row_cnt wrap from the last row.
REQ-018 SHALL compute pixel x=line_cnt>>1 and y=row_cnt-BLACK_TAM_ROW. SHALL output byte0 (line_cnt even) = RGB[15:8] and byte1 = RGB[7:0].
REQ-019 Modes SHALL be: 0 red 16'hF800; 1 green 16'h07E0; 2 blue 16'h001F; 3 colour bars (8 equal bars of width TAM_LINE/8, order white, yellow, cyan, green, magenta, red, blue, black, remainder pixels black); 4 triangle (16'hFFFF when x<TRI_SLOPE*(y+1), else 0). Modes 5..7 SHALL output black.
REQ-020 en deasserted mid-frame SHALL NOT truncate the frame: the frame completes, then the block goes to IDLE.

Reset
REQ-021 While CAM_reset=0, SHALL force: phase/CAM_pclk=0, CAM_vsync=1, CAM_href=0, CAM_px_data=0, frame_start=0, frame_cnt=0, counters=0, latched mode=0, state=IDLE.
REQ-022 SHALL release reset synchronously inside the block. Reset asserted mid-frame SHALL abort the frame immediately, with no partial frame_cnt increment.

Configuration
REQ-023 With CAM_GEN_TRIANGLE_EN defined, mode 4 SHALL produce the triangle pattern. Without it, the triangle logic and its multiplier SHALL be absent and mode 4 SHALL output black.

Structure
REQ-024 Package cam_gen_pkg SHALL hold the mode codes and the RGB565 colour constants (red, green, blue, white, yellow, cyan, magenta, black).
REQ-025 Pattern selection SHALL reside in the purely combinational sub-module cam_px_pattern (inputs: mode, x, y, byte select; output: byte). Timing and the FSM SHALL stay in cam_pattern_gen.

Verification
REQ-026 Defaults, mode=1, en=1 after reset -> per active row, 320 bytes alternating 07,E0. href high for 320 pclk and low for 4. vsync high for rows 0-1. Frame = 124*324 pclk = 80352 clk.
REQ-027 mode=0 then mode=2 written mid-frame -> that frame stays F8,00. The next frame after frame_start is 00,1F. frame_cnt goes 0->1.
REQ-028 TAM_LINE=16, TAM_ROW=4, mode=3 -> each row bytes FF,FF,FF,FF,FF,E0,FF,E0,07,FF,... (2 pixels per bar). Last bar 00,00.
REQ-029 TAM_LINE=8, TAM_ROW=4, TRI_SLOPE=2, mode=4, macro defined -> lit pixels per row: 2,4,6,8. Macro undefined -> all data 00.
REQ-030 en dropped at row 50 -> frame completes, frame_cnt increments once, then vsync=1, href=0, frame_start stays 0. CAM_reset pulsed low mid-row -> all outputs at reset values within the same clk, frame_cnt=0.

Source files
------------

// File: rtl/cam_gen_pkg.sv
// Shared definitions for the camera pattern generator: pattern mode codes,
// FSM states, RGB565 colour constants and the colour-bar lookup.
package cam_gen_pkg;

    typedef enum logic [2:0] {
        MODE_RED   = 3'd0,
        MODE_GREEN = 3'd1,
        MODE_BLUE  = 3'd2,
        MODE_BARS  = 3'd3,
        MODE_TRI   = 3'd4
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_e;

    localparam int COORD_W = 16;

    localparam logic [15:0] COL_RED     = 16'hF800;
    localparam logic [15:0] COL_GREEN   = 16'h07E0;
    localparam logic [15:0] COL_BLUE    = 16'h001F;
    localparam logic [15:0] COL_WHITE   = 16'hFFFF;
    localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
    localparam logic [15:0] COL_CYAN    = 16'h07FF;
    localparam logic [15:0] COL_MAGENTA = 16'hF81F;
    localparam logic [15:0] COL_BLACK   = 16'h0000;

    // Bar order left to right; indices past the eighth bar are the black remainder.
    function automatic logic [15:0] bar_colour(input logic [3:0] idx);
        case (idx)
            4'd0:    return COL_WHITE;
            4'd1:    return COL_YELLOW;
            4'd2:    return COL_CYAN;
            4'd3:    return COL_GREEN;
            4'd4:    return COL_MAGENTA;
            4'd5:    return COL_RED;
            4'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/cam_px_pattern.sv
// Combinational pixel-pattern selector: maps (mode, x, y, byte select) to one
// RGB565 byte. Triangle pattern only exists when CAM_GEN_TRIANGLE_EN is defined.
module cam_px_pattern
    import cam_gen_pkg::*;
#(
    parameter int TAM_LINE  = 160,
    parameter int TRI_SLOPE = 2
) (
    input  logic [2:0]         mode,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               byte_sel,
    output logic [7:0]         px_byte
);

    localparam int BAR_W = TAM_LINE / 8;

    logic [3:0]  bar_idx;
    logic        tri_on;
    logic [15:0] rgb;

`ifdef CAM_GEN_TRIANGLE_EN
    logic [31:0] tri_lim;
    assign tri_lim = 32'(TRI_SLOPE) * ({16'd0, y} + 32'd1);
    assign tri_on  = ({16'd0, x} < tri_lim);
`else
    logic tri_unused;
    assign tri_unused = ^{y, 32'(TRI_SLOPE)};
    assign tri_on     = 1'b0;
`endif

    // Bar index counts how many bar boundaries x has passed, avoiding a divider.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        bar_idx = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            if ({16'd0, x} >= 32'(k * BAR_W)) begin
                bar_idx = bar_idx + 4'd1;
            end
        end
    end

    always_comb begin
        rgb = COL_BLACK;
        case (mode)
            MODE_RED:   rgb = COL_RED;
            MODE_GREEN: rgb = COL_GREEN;
            MODE_BLUE:  rgb = COL_BLUE;
            MODE_BARS:  rgb = bar_colour(bar_idx);
            MODE_TRI:   rgb = tri_on ? COL_WHITE : COL_BLACK;
            default:    rgb = COL_BLACK;
        endcase
    end

    assign px_byte = byte_sel ? rgb[7:0] : rgb[15:8];

endmodule

// File: rtl/cam_pattern_gen.sv
// Camera sensor emulator: generates pclk/vsync/href/data timing for test patterns.
// Define CAM_GEN_TRIANGLE_EN to enable the triangle pattern (mode 4).
module cam_pattern_gen
    import cam_gen_pkg::*;
#(
    parameter int TAM_LINE       = 160,
    parameter int TAM_ROW        = 120,
    parameter int BLACK_TAM_LINE = 4,
    parameter int BLACK_TAM_ROW  = 4,
    parameter int VSYNC_ROWS     = 2,
    parameter int TRI_SLOPE      = 2
) (
    input  logic        clk,
    input  logic        CAM_reset,
    input  logic        en,
    input  logic [2:0]  mode,
    output logic        CAM_pclk,
    output logic        CAM_vsync,
    output logic        CAM_href,
    output logic [7:0]  CAM_px_data,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int LINE_BYTES = 2 * TAM_LINE + BLACK_TAM_LINE;
    localparam int ROWS       = TAM_ROW + BLACK_TAM_ROW;
    localparam int LW         = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
    localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [LW-1:0] LINE_LAST = LW'(LINE_BYTES - 1);
    localparam logic [LW-1:0] ACT_BYTES = LW'(2 * TAM_LINE);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [RW-1:0] ACT_ROW0  = RW'(BLACK_TAM_ROW);
    localparam logic [RW-1:0] VSYNC_LIM = RW'(VSYNC_ROWS);

    logic [1:0]    rst_sync_q, rst_sync_d;
    logic          rst_n;
    logic          phase_q, phase_d;
    state_e        state_q, state_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic [2:0]    mode_q, mode_d;
    logic          frame_start_q, frame_start_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]    pat_byte;

    // NOTE: reset asserts asynchronously but releases on a clk edge so no flop sees a
    // reset edge racing the clock.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge CAM_reset) begin
        if (!CAM_reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    // The update edge is the one where phase_q (pclk) goes 1->0.
    assign phase_d = ~phase_q;

    always_comb begin
        state_d       = state_q;
        line_cnt_d    = line_cnt_q;
        row_cnt_d     = row_cnt_q;
        mode_d        = mode_q;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        if (phase_q) begin
            case (state_q)
                ST_IDLE: begin
                    line_cnt_d = '0;
                    row_cnt_d  = '0;
                    if (en) begin
                        state_d       = ST_FRAME;
                        frame_start_d = 1'b1;
                        mode_d        = mode;
                    end
                end
                ST_FRAME: begin
                    if (line_cnt_q == LINE_LAST) begin
                        line_cnt_d = '0;
                        if (row_cnt_q == ROW_LAST) begin
                            row_cnt_d   = '0;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            if (en) begin
                                frame_start_d = 1'b1;
                                mode_d        = mode;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            row_cnt_d = row_cnt_q + 1'b1;
                        end
                    end else begin
                        line_cnt_d = line_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= 1'b0;
            state_q       <= ST_IDLE;
            line_cnt_q    <= '0;
            row_cnt_q     <= '0;
            mode_q        <= 3'd0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples
            // pre-edge values regardless of statement order.
            phase_q       <= phase_d;
            state_q       <= state_d;
            line_cnt_q    <= line_cnt_d;
            row_cnt_q     <= row_cnt_d;
            mode_q        <= mode_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    cam_px_pattern #(
        .TAM_LINE  (TAM_LINE),
        .TRI_SLOPE (TRI_SLOPE)
    ) u_pattern (
        .mode     (mode_q),
        .x        (COORD_W'(line_cnt_q >> 1)),
        .y        (COORD_W'(row_cnt_q) - COORD_W'(BLACK_TAM_ROW)),
        .byte_sel (line_cnt_q[0]),
        .px_byte  (pat_byte)
    );

    // Outputs decode registered state only, so they settle right after the update edge.
    assign CAM_pclk    = phase_q;
    assign CAM_vsync   = (state_q == ST_FRAME) ? (row_cnt_q < VSYNC_LIM) : 1'b1;
    assign CAM_href    = (state_q == ST_FRAME) && (row_cnt_q >= ACT_ROW0) && (line_cnt_q < ACT_BYTES);
    assign CAM_px_data = CAM_href ? pat_byte : 8'd0;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Directed bench for cam_pattern_gen: default timing, colour bars, mid-frame mode
// and enable changes, triangle pattern (CAM_GEN_TRIANGLE_EN aware), async reset.
module tb_cam_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Default-parameter instance
    logic        d_rst = 1'b0, d_en = 1'b0;
    logic [2:0]  d_mode = 3'd0;
    logic        d_pclk, d_vsync, d_href, d_fs;
    logic [7:0]  d_data;
    logic [15:0] d_fcnt;

    // Small instance: 16 px x 4 rows, 36 bytes per line, 8 rows per frame
    logic        s_rst = 1'b0, s_en = 1'b0;
    logic [2:0]  s_mode = 3'd0;
    logic        s_pclk, s_vsync, s_href, s_fs;
    logic [7:0]  s_data;
    logic [15:0] s_fcnt;

    // Triangle instance: 8 px x 4 rows, 20 bytes per line
    logic        t_rst = 1'b0, t_en = 1'b0;
    logic [2:0]  t_mode = 3'd0;
    logic        t_pclk, t_vsync, t_href, t_fs;
    logic [7:0]  t_data;
    logic [15:0] t_fcnt;

    cam_pattern_gen u_def (
        .clk (clk), .CAM_reset (d_rst), .en (d_en), .mode (d_mode),
        .CAM_pclk (d_pclk), .CAM_vsync (d_vsync), .CAM_href (d_href),
        .CAM_px_data (d_data), .frame_start (d_fs), .frame_cnt (d_fcnt)
    );

    cam_pattern_gen #(.TAM_LINE(16), .TAM_ROW(4)) u_small (
        .clk (clk), .CAM_reset (s_rst), .en (s_en), .mode (s_mode),
        .CAM_pclk (s_pclk), .CAM_vsync (s_vsync), .CAM_href (s_href),
        .CAM_px_data (s_data), .frame_start (s_fs), .frame_cnt (s_fcnt)
    );

    cam_pattern_gen #(.TAM_LINE(8), .TAM_ROW(4), .TRI_SLOPE(2)) u_tri (
        .clk (clk), .CAM_reset (t_rst), .en (t_en), .mode (t_mode),
        .CAM_pclk (t_pclk), .CAM_vsync (t_vsync), .CAM_href (t_href),
        .CAM_px_data (t_data), .frame_start (t_fs), .frame_cnt (t_fcnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic fs_of(input int sel);
        case (sel)
            0:       return d_fs;
            1:       return s_fs;
            default: return t_fs;
        endcase
    endfunction

    // Steps negedges until the selected frame_start is seen; n = clk cycles waited.
    task automatic wait_fs(input int sel, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs_of(sel) && n < bound);
        check("frame_start_seen", 32'(fs_of(sel)), 32'd1);
    endtask

    task automatic step_pclk(input int k);
        repeat (2 * k) @(negedge clk);
    endtask

    logic [7:0] bars_exp [32];
    int         tri_exp [4];
    int         n, lit, fs_seen;

    initial begin
        bars_exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF,  8'hFF, 8'hE0, 8'hFF, 8'hE0,
                     8'h07, 8'hFF, 8'h07, 8'hFF,  8'h07, 8'hE0, 8'h07, 8'hE0,
                     8'hF8, 8'h1F, 8'hF8, 8'h1F,  8'hF8, 8'h00, 8'hF8, 8'h00,
                     8'h00, 8'h1F, 8'h00, 8'h1F,  8'h00, 8'h00, 8'h00, 8'h00};
`ifdef CAM_GEN_TRIANGLE_EN
        tri_exp = '{2, 4, 6, 8};
`else
        tri_exp = '{0, 0, 0, 0};
`endif

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_pclk",  32'(d_pclk),  32'd0);
        check("rst_vsync", 32'(d_vsync), 32'd1);
        check("rst_href",  32'(d_href),  32'd0);
        check("rst_data",  32'(d_data),  32'd0);
        check("rst_fs",    32'(d_fs),    32'd0);
        check("rst_fcnt",  32'(d_fcnt),  32'd0);

        // ---- default timing, green ----
        d_mode = 3'd1;
        d_en   = 1'b1;
        d_rst  = 1'b1;
        wait_fs(0, 20, n);
        check("def_vsync_row0", 32'(d_vsync), 32'd1);
        check("def_href_row0",  32'(d_href),  32'd0);
        n = 0;
        while (d_vsync && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("def_vsync_len_clk", 32'(n), 32'd1296);
        n = 0;
        while (!d_href && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("def_blank_rows_clk", 32'(n), 32'd1296);
        for (int i = 0; i < 324; i++) begin
            check("def_href", 32'(d_href), (i < 320) ? 32'd1 : 32'd0);
            check("def_data", 32'(d_data), (i >= 320) ? 32'h00 : ((i % 2 == 0) ? 32'h07 : 32'hE0));
            step_pclk(1);
        end
        check("def_vsync_active", 32'(d_vsync), 32'd0);
        check("def_fcnt_mid",     32'(d_fcnt),  32'd0);

        // ---- async reset mid-row ----
        repeat (7) @(negedge clk);
        d_rst = 1'b0;
        #1;
        check("midrst_pclk",  32'(d_pclk),  32'd0);
        check("midrst_vsync", 32'(d_vsync), 32'd1);
        check("midrst_href",  32'(d_href),  32'd0);
        check("midrst_data",  32'(d_data),  32'd0);
        check("midrst_fs",    32'(d_fs),    32'd0);
        check("midrst_fcnt",  32'(d_fcnt),  32'd0);

        // ---- colour bars, frame A ----
        s_mode = 3'd3;
        s_en   = 1'b1;
        s_rst  = 1'b1;
        wait_fs(1, 20, n);
        step_pclk(144);
        check("bars_fcnt0", 32'(s_fcnt), 32'd0);
        for (int i = 0; i < 36; i++) begin
            check("bars_href", 32'(s_href), (i < 32) ? 32'd1 : 32'd0);
            check("bars_data", 32'(s_data), (i < 32) ? 32'(bars_exp[i]) : 32'h00);
            step_pclk(1);
        end
        s_mode = 3'd0;
        wait_fs(1, 1000, n);
        check("frameA_tail_clk", 32'(n), 32'd216);
        check("frameA_fcnt",     32'(s_fcnt), 32'd1);

        // ---- frame B: red, mid-frame switch to blue ignored ----
        step_pclk(144);
        check("red_b0", 32'(s_data), 32'hF8);
        step_pclk(1);
        check("red_b1", 32'(s_data), 32'h00);
        step_pclk(1);
        s_mode = 3'd2;
        step_pclk(36);
        check("red_hold_b0", 32'(s_data), 32'hF8);
        step_pclk(1);
        check("red_hold_b1", 32'(s_data), 32'h00);
        step_pclk(1);
        wait_fs(1, 1000, n);
        check("frameB_tail_clk", 32'(n), 32'd208);
        check("frameB_fcnt",     32'(s_fcnt), 32'd2);

        // ---- frame C: blue, en dropped mid-frame ----
        step_pclk(144);
        check("blue_b0", 32'(s_data), 32'h00);
        step_pclk(1);
        check("blue_b1", 32'(s_data), 32'h1F);
        step_pclk(1);
        s_en = 1'b0;
        step_pclk(36);
        check("endrop_href_running",  32'(s_href),  32'd1);
        check("endrop_vsync_running", 32'(s_vsync), 32'd0);
        n = 0;
        while (s_fcnt != 16'd3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("endrop_tail_clk", 32'(n), 32'd212);
        check("endrop_fcnt",     32'(s_fcnt),  32'd3);
        check("endrop_vsync",    32'(s_vsync), 32'd1);
        check("endrop_href",     32'(s_href),  32'd0);
        check("endrop_data",     32'(s_data),  32'd0);
        check("endrop_fs",       32'(s_fs),    32'd0);
        fs_seen = 0;
        repeat (1200) begin
            @(negedge clk);
            if (s_fs) fs_seen++;
        end
        check("idle_fs_count", 32'(fs_seen), 32'd0);
        check("idle_fcnt",     32'(s_fcnt),  32'd3);
        check("idle_href",     32'(s_href),  32'd0);
        check("idle_vsync",    32'(s_vsync), 32'd1);

        // ---- triangle ----
        t_mode = 3'd4;
        t_en   = 1'b1;
        t_rst  = 1'b1;
        wait_fs(2, 20, n);
        step_pclk(80);
        for (int r = 0; r < 4; r++) begin
            lit = 0;
            for (int i = 0; i < 20; i++) begin
                if (i % 2 == 0 && t_data == 8'hFF) lit++;
                step_pclk(1);
            end
            check("tri_lit_row", 32'(lit), 32'(tri_exp[r]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
